ram_bridge_tx: RTL

UART read-back responder for program/data memory; the transmit-side counterpart of the host "W" write bridge. It parses host command "R" followed by a 4-byte big-endian address from the uart_rx byte stream and issues one memory read. It then returns the 32-bit word over its own 8N1 serial transmitter, most significant byte first. It sits beside the write bridge inside program_ram, sharing the uart_rx output and driving the board UART TX pin.

---
 rtl/ram_bridge_tx_if.sv | 20 ++
 rtl/ram_bridge_tx.sv | 111 +++++++++++
 2 files changed

// File: rtl/ram_bridge_tx_if.sv
// ram_bridge_tx_if: host byte stream, memory read port and serial/status lines of the read-back bridge
// slave modport: the bridge (consumes rx bytes and read data, drives address/strobe/tx/busy)
// master modport: the surrounding logic or bench (drives rx bytes and read data)
interface ram_bridge_tx_if;
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic [31:0] mem_addr_out;
  logic        mem_rd_out;
  logic [31:0] mem_data_in;
  logic        uart_tx_out;
  logic        busy_out;
  modport slave (
    input  rx_data_in, rx_valid_in, mem_data_in,
    output mem_addr_out, mem_rd_out, uart_tx_out, busy_out
  );
  modport master (
    output rx_data_in, rx_valid_in, mem_data_in,
    input  mem_addr_out, mem_rd_out, uart_tx_out, busy_out
  );
endinterface

// File: rtl/ram_bridge_tx.sv
// ram_bridge_tx: parses "R"+4-byte big-endian address, reads one memory word, returns it MSB byte first over 8N1
// Ports: clk_in system clock; rst_n_in async active-low reset; bus (slave) carries
//   rx_data_in/rx_valid_in from uart_rx, mem_addr_out/mem_rd_out/mem_data_in read port,
//   uart_tx_out serial line (idle high), busy_out high whenever not IDLE.
// Option: define RAM_BRIDGE_TX_CHECKSUM_EN to append a fifth frame holding the XOR of the four data bytes.
module ram_bridge_tx #(
  parameter int unsigned CLOCKS_PER_BAUD = 33,
  parameter int unsigned READ_LATENCY    = 2,
  parameter logic [7:0]  CMD_CHAR        = 8'h52
) (
  input logic          clk_in,
  input logic          rst_n_in,
  ram_bridge_tx_if.slave bus
);
`ifdef RAM_BRIDGE_TX_CHECKSUM_EN
  localparam int unsigned NF = 5;
`else
  localparam int unsigned NF = 4;
`endif
  localparam int unsigned BUF_W  = 8 * NF;
  localparam int unsigned BAUD_W = $clog2(CLOCKS_PER_BAUD);
  localparam int unsigned WAIT_W = $clog2(READ_LATENCY + 1);
  localparam int unsigned BYTE_W = $clog2(NF);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NF - 1);
  localparam logic [BYTE_W-1:0] ADDR_LAST = BYTE_W'(3);
  typedef enum logic [1:0] {IDLE, ADDR, READ, SEND} state_t;
  state_t            state, state_nx;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [23:0]       addr_q;
  logic [BUF_W-1:0]  tx_buf, cap;
  logic [7:0]        cur;
  logic              cmd_hit, addr_done, read_done, bit_end, frame_end, last_frame;
  always_comb begin
    cmd_hit    = bus.rx_valid_in && bus.rx_data_in == CMD_CHAR;
    addr_done  = bus.rx_valid_in && byte_cnt == ADDR_LAST;
    read_done  = wait_cnt == WAIT_LAST;
    bit_end    = baud_cnt == BAUD_LAST;
    frame_end  = bit_end && bit_cnt == 4'd9;
    last_frame = byte_cnt == BYTE_LAST;
    cur        = tx_buf[BUF_W-1 -: 8];
`ifdef RAM_BRIDGE_TX_CHECKSUM_EN
    cap = {bus.mem_data_in, bus.mem_data_in[31:24] ^ bus.mem_data_in[23:16] ^ bus.mem_data_in[15:8] ^ bus.mem_data_in[7:0]};
`else
    cap = bus.mem_data_in;
`endif
    state_nx = state == IDLE && cmd_hit                ? ADDR :
               state == ADDR && addr_done              ? READ :
               state == READ && read_done              ? SEND :
               state == SEND && frame_end && last_frame ? IDLE : state;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else state <= state_nx;
  end
  // bit_cnt walks 0 (start), 1..8 (data LSB first), 9 (stop); the line is registered, so each
  // transition loads the level of the bit that begins on the next cycle
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.mem_addr_out <= '0;
      bus.mem_rd_out   <= 1'b0;
      bus.uart_tx_out  <= 1'b1;
      bus.busy_out     <= 1'b0;
      baud_cnt         <= '0;
      bit_cnt          <= '0;
      byte_cnt         <= '0;
      wait_cnt         <= '0;
      addr_q           <= '0;
      tx_buf           <= '0;
    end else begin
      bus.busy_out   <= state_nx != IDLE;
      bus.mem_rd_out <= 1'b0;
      case (state)
        ADDR: if (bus.rx_valid_in) begin
          addr_q   <= {addr_q[15:0], bus.rx_data_in};
          byte_cnt <= addr_done ? '0 : byte_cnt + 1'b1;
          if (addr_done) begin
            bus.mem_addr_out <= {addr_q, bus.rx_data_in};
            bus.mem_rd_out   <= 1'b1;
            wait_cnt         <= '0;
          end
        end
        READ: if (read_done) begin
          tx_buf          <= cap;
          bus.uart_tx_out <= 1'b0;
          baud_cnt        <= '0;
          bit_cnt         <= '0;
          byte_cnt        <= '0;
        end else wait_cnt <= wait_cnt + 1'b1;
        SEND: if (!bit_end) baud_cnt <= baud_cnt + 1'b1;
        else begin
          baud_cnt <= '0;
          if (bit_cnt == 4'd9) begin
            bit_cnt         <= '0;
            byte_cnt        <= last_frame ? '0 : byte_cnt + 1'b1;
            tx_buf          <= {tx_buf[BUF_W-9:0], 8'h00};
            bus.uart_tx_out <= last_frame;
          end else begin
            bit_cnt         <= bit_cnt + 1'b1;
            bus.uart_tx_out <= bit_cnt == 4'd8 ? 1'b1 : cur[bit_cnt[2:0]];
          end
        end
        default: ;
      endcase
    end
  end
endmodule
